// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package divider_pkg;

  // Default operand/result width.
  localparam int DEF_W = 8;

  // Fixed FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

  // Iteration counter width for the default width; must be able to hold W.
  localparam int CNT_W = $clog2(DEF_W + 1);

  // Same rule for any other width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract, keep or restore.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   part_rem  - shifted partial remainder (W+1 bits, so the compare never overflows)
//   divisor   - unsigned divisor
//   next_rem  - remainder after this step (always < divisor, so W bits suffice)
//   q_bit     - quotient bit produced by this step
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   part_rem,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_rem,
  output logic         q_bit
);

  logic [W:0] dvs_ext;
  logic [W:0] diff;

  assign dvs_ext = {1'b0, divisor};
  assign diff    = part_rem - dvs_ext;
  assign q_bit   = (part_rem >= dvs_ext);
  // On subtract, diff < divisor so its top bit is zero; on restore,
  // part_rem < divisor likewise. Dropping bit W is therefore lossless.
  assign next_rem = q_bit ? diff[W-1:0] : part_rem[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, restoring radix-2, one quotient bit per clock.
// Latency: W cycles from accepting edge to done; one result per W+1 cycles back-to-back.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   start, dividend, divisor - request and operands (sampled on the accepting edge)
//   busy, done              - CALC / one-cycle DONE indication
//   quotient, remainder, div_by_zero - result registers, held until next DONE
module seq_divider
  import divider_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;     // partial remainder
  logic [W-1:0]  dq;      // dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]  dvs;     // latched divisor

  logic [W:0]    shifted;
  logic [W-1:0]  step_rem;
  logic          step_q;

  // Bring down the next dividend bit, MSB first.
  assign shifted = {rem, dq[W-1]};

  div_step #(.W(W)) u_step (
    .part_rem (shifted),
    .divisor  (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          rem <= step_rem;
          dq  <= {dq[W-2:0], step_q};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Results only change here, so nothing partial is ever visible.
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= {dq[W-2:0], step_q};
            remainder   <= step_rem;
            div_by_zero <= (dvs == '0);
          end
        end
        default: begin  // IDLE and DONE both accept a new request
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
            rem   <= '0;
            dq    <= dividend;
            dvs   <= divisor;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (W=8) plus exhaustive W=4 sweep.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, z4;
  logic [3:0] q4, r4;

  int checks = 0;
  int failures = 0;

  seq_divider #(.W(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  seq_divider #(.W(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start4),
    .dividend    (a4),
    .divisor     (b4),
    .busy        (busy4),
    .done        (done4),
    .quotient    (q4),
    .remainder   (r4),
    .div_by_zero (z4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_q"},    32'(quotient), 32'd0);
    chk({tag, "_r"},    32'(remainder), 32'd0);
    chk({tag, "_dbz"},  32'(div_by_zero), 32'd0);
  endtask

  // Present a request at a negedge; returns at the negedge after acceptance.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Count remaining busy cycles (bounded), then check the DONE cycle.
  task automatic finish_op(input string tag, input int exp_cycles,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_done"},        32'(done), 32'd1);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_q"},           32'(quotient), 32'(eq));
    chk({tag, "_r"},           32'(remainder), 32'(er));
    chk({tag, "_dbz"},         32'(div_by_zero), 32'(ez));
  endtask

  initial begin
    logic saw_done;
    int   n;
    logic [3:0]  eq4, er4;
    logic        ez4;
    logic [12:0] obs4, exp4;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 100/7: 8 busy cycles, then 14 r 2.
    launch(8'd100, 8'd7);
    finish_op("100div7", 8, 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    chk("after_done_pulse", 32'(done), 32'd0);
    chk("hold_q", 32'(quotient), 32'd14);
    chk("hold_r", 32'(remainder), 32'd2);

    // Divide by zero.
    launch(8'd255, 8'd0);
    finish_op("255div0", 8, 8'd255, 8'd255, 1'b1);

    // Zero dividend, launched straight from DONE; prior result held during CALC.
    launch(8'd0, 8'd5);
    chk("calc_holds_prev_q", 32'(quotient), 32'd255);
    finish_op("0div5", 8, 8'd0, 8'd0, 1'b0);

    // 200/3 with an ignored request on CALC cycle 3.
    launch(8'd200, 8'd3);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("calc_no_partial_q", 32'(quotient), 32'd0);
    finish_op("200div3", 5, 8'd66, 8'd2, 1'b0);

    // Start held in DONE goes straight back to CALC.
    launch(8'd50, 8'd5);
    finish_op("50div5", 8, 8'd10, 8'd0, 1'b0);

    // Reset on CALC cycle 4 of 77/4.
    launch(8'd77, 8'd4);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("aborted_no_done", 32'(saw_done), 32'd0);
    chk("aborted_idle_busy", 32'(busy), 32'd0);
    launch(8'd9, 8'd2);
    finish_op("9div2", 8, 8'd4, 8'd1, 1'b0);
    @(negedge clk);

    // W=4 exhaustive sweep against a golden model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a);
        b4 = 4'(b);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
          n++;
          @(negedge clk);
        end
        if (b == 0) begin
          eq4 = 4'hF; er4 = 4'(a); ez4 = 1'b1;
        end else begin
          eq4 = 4'(a / b); er4 = 4'(a % b); ez4 = 1'b0;
        end
        obs4 = {n[3:0], q4, r4, z4};
        exp4 = {4'd4, eq4, er4, ez4};
        $display("w4 pair %0d/%0d %s", a, b, (obs4 === exp4) ? "correct" : "WRONG_RESULT");
        chk("w4_pair", 32'(obs4), 32'(exp4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits (W >= 2).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled on rising clk edge.
REQ-005 dividend  input  W  unsigned numerator; sampled only on the accepting edge.
REQ-006 divisor  input  W  unsigned denominator; sampled only on the accepting edge.
REQ-007 busy  output  1  high while an operation is in progress (CALC state).
REQ-008 done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid.
REQ-009 quotient  output  W  unsigned floor(dividend/divisor).
REQ-010 remainder  output  W  unsigned dividend mod divisor.
REQ-011 div_by_zero  output  1  high when the completed operation had divisor == 0.

Function
REQ-012 FSM states: IDLE, CALC, DONE; encoding is fixed in the shared package.
REQ-013 Acceptance: start == 1 at a rising edge while in IDLE or DONE; operands latched, iteration counter cleared, state -> CALC.
REQ-014 start while in CALC is ignored; no effect on latched operands, counter or outputs.
REQ-015 Algorithm: restoring radix-2 division, one quotient bit per CLK, MSB first.
- Partial remainder: W+1 bits, so the compare never overflows.
REQ-016 CALC lasts exactly W cycles; after the W-th iteration edge, state -> DONE.
- quotient, remainder and div_by_zero register on that same edge.
REQ-017 Latency: acceptance at edge 0 -> done high during the cycle after edge W; W cycles total.
REQ-018 DONE lasts one cycle; next edge -> CALC if start == 1, else IDLE. Back-to-back throughput is one result per W+1 cycles.
REQ-019 done == 1 exactly in DONE; busy == 1 exactly in CALC; never both.
REQ-020 quotient, remainder and div_by_zero hold their last values until the next DONE entry.
REQ-021 Divisor == 0: no special path; same latency.
- quotient = all ones (2^W-1), remainder = dividend, div_by_zero = 1.
REQ-022 dividend < divisor: quotient = 0, remainder = dividend. dividend == 0: quotient = 0, remainder = 0.
REQ-023 No intermediate or partial result is visible on quotient or remainder during CALC.

Reset
REQ-024 rst_n low: state -> IDLE and the counter clears immediately, independent of clk.
- busy, done, quotient, remainder and div_by_zero all go to 0.
REQ-025 Reset during CALC aborts the operation; no done pulse for it; the first edge after release with start == 1 is accepted normally.

Structure
REQ-026 Shared package divider_pkg contains:
- FSM state localparams (IDLE, CALC, DONE);
- the default width constant;
- the counter width, equal to clog2(W+1).
REQ-027 One combinational sub-module div_step, used once:
- inputs: partial remainder (W+1 bits) and divisor;
- outputs: next partial remainder and quotient bit.
REQ-028 Top level contains only the FSM, the counter and the operand/result registers.

Verification (W = 8 unless stated)
REQ-029 dividend=100, divisor=7, start pulse -> busy for 8 cycles, then done 1 cycle with quotient=14, remainder=2, div_by_zero=0.
REQ-030 dividend=255, divisor=0 -> after 8 cycles, quotient=255, remainder=255, div_by_zero=1; dividend=0, divisor=5 -> quotient=0, remainder=0.
REQ-031 Start 200/3, then assert start with 50/5 on cycle 3 of CALC:
- second request ignored; result quotient=66, remainder=2;
- holding start high in DONE then starts 50/5 immediately -> quotient=10, remainder=0.
REQ-032 Reset asserted on cycle 4 of CALC (operation 77/4):
- all outputs 0 immediately; no done pulse;
- next operation 9/2 -> quotient=4, remainder=1.
REQ-033 W = 4 exhaustive: all 256 dividend/divisor pairs.
- Check on each done: quotient == a/b and remainder == a%b against a golden model; divisor 0 checked against REQ-021.
- Print correct/WRONG_RESULT per pair and count mismatches; zero mismatches required.
